// File: rtl/scproc_pkg.sv
// Shared I/O map offsets and control-register bit positions for the memory responder.
// Offsets are byte distances from the responder's IO_BASE parameter.
package scproc_pkg;

  localparam int unsigned HEX_OFF   = 32'h000;
  localparam int unsigned LEDR_OFF  = 32'h004;
  localparam int unsigned KDATA_OFF = 32'h010;
  localparam int unsigned KCTRL_OFF = 32'h014;
  localparam int unsigned SDATA_OFF = 32'h020;
  localparam int unsigned SCTRL_OFF = 32'h024;
  localparam int unsigned TCNT_OFF  = 32'h100;
  localparam int unsigned TLIM_OFF  = 32'h104;
  localparam int unsigned TCTRL_OFF = 32'h108;

  localparam int READY_BIT   = 0;
  localparam int OVERRUN_BIT = 2;

  typedef logic [2:0] ctrl_t;

  function automatic ctrl_t packCtrl(input logic ready, input logic overrun);
    ctrl_t c;
    c = '0;
    c[READY_BIT]   = ready;
    c[OVERRUN_BIT] = overrun;
    return c;
  endfunction

endpackage

// File: rtl/scproc_io_flag.sv
// Ready/overrun flag pair for one input source; readable as a 3-bit control word.
// Updates on the clock edge; a hardware event always beats a same-cycle software write.
module scproc_io_flag
  import scproc_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  evt,
  input  logic  wrEn,
  input  logic  wrReady,
  input  logic  wrOverrun,
  output ctrl_t ctrl
);

  logic ready;
  logic overrun;

  // Overrun looks at ready as it stood at the start of the cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      ready   <= evt | (wrEn ? wrReady : ready);
      overrun <= (evt & ready) | (wrEn ? wrOverrun : overrun);
    end
  end

  assign ctrl = packCtrl(ready, overrun);

endmodule

// File: rtl/scproc_mem_responder.sv
// Data RAM plus memory-mapped LED/HEX/KEY/SW/timer behind the processor memory port; zero-cycle reads, stores commit on clk when lock is high.
// Timer block is built only when SCPROC_MEM_TIMER_EN is defined; otherwise its registers read 0.
module scproc_mem_responder
  import scproc_pkg::*;
#(
  parameter int               DBITS      = 32,
  parameter int               DMEM_WORDS = 2048,
  parameter int               CLK_PER_MS = 50000,
  parameter logic [DBITS-1:0] IO_BASE    = DBITS'(32'hF000_0000)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             lock,
  input  logic [DBITS-1:0] addr,
  input  logic             wrtEn,
  input  logic [DBITS-1:0] wrtData,
  output logic [DBITS-1:0] rdData,
  input  logic [3:0]       key,
  input  logic [9:0]       sw,
  output logic [9:0]       ledr,
  output logic [23:0]      hex
);

  localparam int AW = $clog2(DMEM_WORDS);
  localparam int OW = DBITS - 2;

  logic [DBITS-1:0] mem [DMEM_WORDS];
  logic [AW-1:0]    wordIdx;
  logic             isIo;
  logic [OW-1:0]    ioWord;
  logic             commit;
  logic             unusedLowAddr;

  assign wordIdx       = addr[AW+1:2];
  assign isIo          = addr >= IO_BASE;
  assign ioWord        = addr[DBITS-1:2] - IO_BASE[DBITS-1:2];
  assign commit        = wrtEn & lock;
  assign unusedLowAddr = ^addr[1:0];

  function automatic logic hitIo(input logic [OW-1:0] w, input int unsigned off);
    return w == OW'(off >> 2);
  endfunction

  logic hexWe, ledrWe, kctrlWe, sctrlWe;
  assign hexWe   = commit & isIo & hitIo(ioWord, HEX_OFF);
  assign ledrWe  = commit & isIo & hitIo(ioWord, LEDR_OFF);
  assign kctrlWe = commit & isIo & hitIo(ioWord, KCTRL_OFF);
  assign sctrlWe = commit & isIo & hitIo(ioWord, SCTRL_OFF);

  // RAM has no reset; an interrupted store leaves only its own word undefined.
  always_ff @(posedge clk) begin
    if (commit && !isIo) mem[wordIdx] <= wrtData;
  end

  logic [23:0] hexReg;
  logic [9:0]  ledrReg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hexReg  <= '0;
      ledrReg <= '0;
    end else begin
      if (hexWe)  hexReg  <= wrtData[23:0];
      if (ledrWe) ledrReg <= wrtData[9:0];
    end
  end

  assign hex  = hexReg;
  assign ledr = ledrReg;

  logic [3:0] keySync1, keySync2, keyPrev;
  logic [9:0] swSync1, swSync2, swPrev;
  logic       keyEvt, swEvt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      keySync1 <= '0;
      keySync2 <= '0;
      keyPrev  <= '0;
      swSync1  <= '0;
      swSync2  <= '0;
      swPrev   <= '0;
    end else begin
      keySync1 <= key;
      keySync2 <= keySync1;
      keyPrev  <= keySync2;
      swSync1  <= sw;
      swSync2  <= swSync1;
      swPrev   <= swSync2;
    end
  end

  assign keyEvt = |(keySync2 ^ keyPrev);
  assign swEvt  = |(swSync2 ^ swPrev);

  ctrl_t kctrl, sctrl;

  scproc_io_flag uKeyFlag (
    .clk       (clk),
    .reset_n   (reset_n),
    .evt       (keyEvt),
    .wrEn      (kctrlWe),
    .wrReady   (wrtData[READY_BIT]),
    .wrOverrun (wrtData[OVERRUN_BIT]),
    .ctrl      (kctrl)
  );

  scproc_io_flag uSwFlag (
    .clk       (clk),
    .reset_n   (reset_n),
    .evt       (swEvt),
    .wrEn      (sctrlWe),
    .wrReady   (wrtData[READY_BIT]),
    .wrOverrun (wrtData[OVERRUN_BIT]),
    .ctrl      (sctrl)
  );

`ifdef SCPROC_MEM_TIMER_EN
  localparam int PW = $clog2(CLK_PER_MS);

  logic [PW-1:0]    presc;
  logic [DBITS-1:0] tcnt, tlim;
  logic             tick, tcntWe, tlimWe, tctrlWe, timerEvt, atLimit;
  ctrl_t            tctrl;

  assign tcntWe   = commit & isIo & hitIo(ioWord, TCNT_OFF);
  assign tlimWe   = commit & isIo & hitIo(ioWord, TLIM_OFF);
  assign tctrlWe  = commit & isIo & hitIo(ioWord, TCTRL_OFF);
  assign tick     = presc == PW'(CLK_PER_MS - 1);
  assign atLimit  = tcnt == (tlim - DBITS'(1));
  // A software load of TCNT swallows a coincident tick, including its wrap event.
  assign timerEvt = !tcntWe && (tlim != '0) && tick && atLimit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      tcnt  <= '0;
      tlim  <= '0;
    end else begin
      if (tlimWe) tlim <= wrtData;
      if (tcntWe) begin
        tcnt  <= wrtData;
        presc <= '0;
      end else if (tlim != '0) begin
        if (tick) begin
          presc <= '0;
          tcnt  <= atLimit ? '0 : tcnt + DBITS'(1);
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  scproc_io_flag uTimerFlag (
    .clk       (clk),
    .reset_n   (reset_n),
    .evt       (timerEvt),
    .wrEn      (tctrlWe),
    .wrReady   (wrtData[READY_BIT]),
    .wrOverrun (wrtData[OVERRUN_BIT]),
    .ctrl      (tctrl)
  );
`endif

  always_comb begin
    rdData = '0;
    if (!isIo) begin
      rdData = mem[wordIdx];
    end else if (hitIo(ioWord, HEX_OFF)) begin
      rdData = DBITS'(hexReg);
    end else if (hitIo(ioWord, LEDR_OFF)) begin
      rdData = DBITS'(ledrReg);
    end else if (hitIo(ioWord, KDATA_OFF)) begin
      rdData = DBITS'(keySync2);
    end else if (hitIo(ioWord, KCTRL_OFF)) begin
      rdData = DBITS'(kctrl);
    end else if (hitIo(ioWord, SDATA_OFF)) begin
      rdData = DBITS'(swSync2);
    end else if (hitIo(ioWord, SCTRL_OFF)) begin
      rdData = DBITS'(sctrl);
`ifdef SCPROC_MEM_TIMER_EN
    end else if (hitIo(ioWord, TCNT_OFF)) begin
      rdData = tcnt;
    end else if (hitIo(ioWord, TLIM_OFF)) begin
      rdData = tlim;
    end else if (hitIo(ioWord, TCTRL_OFF)) begin
      rdData = DBITS'(tctrl);
`endif
    end
  end

endmodule
